// File: rtl/viterbi_stream_if.sv
// rtl/viterbi_stream_if.sv - host-side stream bundle for viterbi_stream_top
//
// Purpose: groups the coded-word input, decoded-word output and status signals
// of viterbi_stream_top so the host and the decoder share one connection.
// Ports (signals):
//   dvalid_i, data_i[IN_W]  coded word strobe and payload (host -> decoder)
//   full_o                  input FIFO full (decoder -> host)
//   pause_i                 hold the serializer at the next word boundary
//   data_o[OUT_W], valid_o  decoded word at the output FIFO head
//   ready_i                 host accepts data_o
//   in_drop_o, out_drop_o   saturating drop counters
//   idle_o                  nothing buffered anywhere in the wrapper
// Modports: master = host side, slave = decoder side.
interface viterbi_stream_if #(
  parameter int IN_W  = 16,
  parameter int OUT_W = 8,
  parameter int CNT_W = 8
);
  logic             dvalid_i;
  logic [IN_W-1:0]  data_i;
  logic             full_o;
  logic             pause_i;
  logic [OUT_W-1:0] data_o;
  logic             valid_o;
  logic             ready_i;
  logic [CNT_W-1:0] in_drop_o;
  logic [CNT_W-1:0] out_drop_o;
  logic             idle_o;

  modport master (
    output dvalid_i, data_i, pause_i, ready_i,
    input  full_o, data_o, valid_o, in_drop_o, out_drop_o, idle_o
  );

  modport slave (
    input  dvalid_i, data_i, pause_i, ready_i,
    output full_o, data_o, valid_o, in_drop_o, out_drop_o, idle_o
  );
endinterface

// File: rtl/viterbi_stream_top.sv
// rtl/viterbi_stream_top.sv - streaming wrapper around a K=3 (7,5) Viterbi decoder
//
// viterbi_core: hard-decision register-exchange decoder for the rate-1/2, K=3
//   code with generators 7 (g0, symbol MSB) and 5 (g1, symbol LSB).
//   Ports: clk, rst_n (async, active-low), valid_i/symbol_i[2] in,
//   valid_serial_o/data_serial_o out. Bit n is released with symbol n+TBL+1.
// viterbi_stream_top: input word FIFO -> gap-free symbol serializer -> core ->
//   MSB-first bit packer -> first-word-fall-through output FIFO.
//   Ports: clk, rst (async, active-high), bus (viterbi_stream_if.slave).
module viterbi_core #(
  parameter int TBL      = 15,
  parameter int PM_WIDTH = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       valid_i,
  input  logic [1:0] symbol_i,
  output logic       valid_serial_o,
  output logic       data_serial_o
);
  localparam int L  = TBL + 1;
  localparam int SW = $clog2(L + 1);

  logic [PM_WIDTH-1:0] pm_q [4];
  logic [PM_WIDTH-1:0] pm_d [4];
  logic [PM_WIDTH-1:0] cost_d [4];
  logic [L-1:0]        path_q [4];
  logic [L-1:0]        path_d [4];
  logic [SW-1:0]       seen_q;
  logic [1:0]          best, ns, pa, pb;
  logic [PM_WIDTH-1:0] ca, cb, min_cost;
  logic                valid_q, bit_q;

  // Hamming distance between the received symbol and the branch output
  // leaving state p={newest,oldest} on input bit b.
  function automatic logic [1:0] branch_metric(input logic [1:0] p, input logic b,
                                               input logic [1:0] sym);
    logic g0, g1;
    g0 = b ^ p[1] ^ p[0];
    g1 = b ^ p[0];
    return {1'b0, g0 ^ sym[1]} + {1'b0, g1 ^ sym[0]};
  endfunction

  always_comb begin
    best     = 2'd0;
    ns       = 2'd0;
    pa       = 2'd0;
    pb       = 2'd0;
    ca       = '0;
    cb       = '0;
    for (int s = 1; s < 4; s++)
      if (pm_q[s] < pm_q[best]) best = 2'(s);
    // State {b, x} is reached from {x,0} or {x,1} with input bit b.
    for (int s = 0; s < 4; s++) begin
      ns = 2'(s);
      pa = {ns[0], 1'b0};
      pb = {ns[0], 1'b1};
      ca = pm_q[pa] + PM_WIDTH'(branch_metric(pa, ns[1], symbol_i));
      cb = pm_q[pb] + PM_WIDTH'(branch_metric(pb, ns[1], symbol_i));
      if (cb < ca) begin
        cost_d[s] = cb;
        path_d[s] = {path_q[pb][L-2:0], ns[1]};
      end else begin
        cost_d[s] = ca;
        path_d[s] = {path_q[pa][L-2:0], ns[1]};
      end
    end
    // Renormalise so the best metric is always zero and nothing overflows.
    min_cost = cost_d[0];
    for (int s = 1; s < 4; s++)
      if (cost_d[s] < min_cost) min_cost = cost_d[s];
    for (int s = 0; s < 4; s++)
      pm_d[s] = cost_d[s] - min_cost;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // Encoder starts in state 0; other states get a head-start penalty.
      for (int s = 0; s < 4; s++) begin
        pm_q[s]   <= (s == 0) ? '0 : PM_WIDTH'(4);
        path_q[s] <= '0;
      end
      seen_q  <= '0;
      valid_q <= 1'b0;
      bit_q   <= 1'b0;
    end else begin
      // Oldest bit of the best survivor leaves once the window is full.
      valid_q <= valid_i && (seen_q == SW'(L));
      bit_q   <= path_q[best][L-1];
      if (valid_i) begin
        for (int s = 0; s < 4; s++) begin
          pm_q[s]   <= pm_d[s];
          path_q[s] <= path_d[s];
        end
        if (seen_q != SW'(L)) seen_q <= seen_q + SW'(1);
      end
    end
  end

  assign valid_serial_o = valid_q;
  assign data_serial_o  = bit_q;
endmodule

module viterbi_stream_top #(
  parameter int IN_W        = 16,
  parameter int OUT_W       = 8,
  parameter int IFIFO_DEPTH = 16,
  parameter int OFIFO_DEPTH = 8,
  parameter int TBL         = 15,
  parameter int PM_WIDTH    = 8,
  parameter int CNT_W       = 8
) (
  input logic             clk,
  input logic             rst,
  viterbi_stream_if.slave bus
);
  localparam int IA   = $clog2(IFIFO_DEPTH);
  localparam int OA   = $clog2(OFIFO_DEPTH);
  localparam int NSYM = IN_W / 2;
  localparam int SCW  = $clog2(NSYM);
  localparam int PCW  = $clog2(OUT_W);

  typedef enum logic {S_EMPTY = 1'b0, S_SHIFT = 1'b1} ser_state_e;

  logic [IN_W-1:0]  imem [IFIFO_DEPTH];
  logic [OUT_W-1:0] omem [OFIFO_DEPTH];
  logic [IA:0]      iwr_q, ird_q;
  logic [OA:0]      owr_q, ord_q;
  ser_state_e       state_q, state_d;
  logic [IN_W-1:0]  sreg_q, sreg_d;
  logic [SCW-1:0]   scnt_q, scnt_d;
  logic [OUT_W-1:0] pk_q, pk_word;
  logic [PCW-1:0]   pcnt_q;
  logic [CNT_W-1:0] in_drop_q, out_drop_q;
  logic ifull, iempty, ipush, ipop, idrop, can_load;
  logic ofull, oempty, opush, opop, oaccept, odrop;
  logic core_valid, dec_valid, dec_bit;
  logic [1:0] core_sym;

  // Extra wrap bit on each pointer: equal = empty, only MSB differs = full.
  assign ifull    = (iwr_q[IA] != ird_q[IA]) && (iwr_q[IA-1:0] == ird_q[IA-1:0]);
  assign iempty   = (iwr_q == ird_q);
  assign ipush    = bus.dvalid_i && !ifull;
  assign idrop    = bus.dvalid_i && ifull;
  assign can_load = !iempty && !bus.pause_i;

  always_ff @(posedge clk) begin
    if (ipush) imem[iwr_q[IA-1:0]] <= bus.data_i;
  end

  always_comb begin
    state_d = state_q;
    sreg_d  = sreg_q;
    scnt_d  = scnt_q;
    ipop    = 1'b0;
    case (state_q)
      S_EMPTY: begin
        if (can_load) begin
          ipop    = 1'b1;
          sreg_d  = imem[ird_q[IA-1:0]];
          scnt_d  = '0;
          state_d = S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (scnt_q == SCW'(NSYM - 1)) begin
          // Reload on the last symbol so back-to-back words leave no bubble.
          if (can_load) begin
            ipop   = 1'b1;
            sreg_d = imem[ird_q[IA-1:0]];
            scnt_d = '0;
          end else begin
            state_d = S_EMPTY;
          end
        end else begin
          sreg_d = sreg_q << 2;
          scnt_d = scnt_q + SCW'(1);
        end
      end
      default: state_d = S_EMPTY;
    endcase
  end

  assign core_valid = (state_q == S_SHIFT);
  assign core_sym   = sreg_q[IN_W-1 -: 2];

  viterbi_core #(.TBL(TBL), .PM_WIDTH(PM_WIDTH)) u_core (
    .clk            (clk),
    .rst_n          (~rst),
    .valid_i        (core_valid),
    .symbol_i       (core_sym),
    .valid_serial_o (dec_valid),
    .data_serial_o  (dec_bit)
  );

  // Shift-left packer: after OUT_W bits the first one sits in the MSB.
  assign pk_word = {pk_q[OUT_W-2:0], dec_bit};
  assign opush   = dec_valid && (pcnt_q == PCW'(OUT_W - 1));

  assign ofull   = (owr_q[OA] != ord_q[OA]) && (owr_q[OA-1:0] == ord_q[OA-1:0]);
  assign oempty  = (owr_q == ord_q);
  assign opop    = !oempty && bus.ready_i;
  assign oaccept = opush && (!ofull || opop);
  assign odrop   = opush && !oaccept;

  always_ff @(posedge clk) begin
    if (oaccept) omem[owr_q[OA-1:0]] <= pk_word;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_EMPTY;
      sreg_q     <= '0;
      scnt_q     <= '0;
      iwr_q      <= '0;
      ird_q      <= '0;
      owr_q      <= '0;
      ord_q      <= '0;
      pk_q       <= '0;
      pcnt_q     <= '0;
      in_drop_q  <= '0;
      out_drop_q <= '0;
    end else begin
      state_q <= state_d;
      sreg_q  <= sreg_d;
      scnt_q  <= scnt_d;
      if (ipush)   iwr_q <= iwr_q + (IA+1)'(1);
      if (ipop)    ird_q <= ird_q + (IA+1)'(1);
      if (oaccept) owr_q <= owr_q + (OA+1)'(1);
      if (opop)    ord_q <= ord_q + (OA+1)'(1);
      if (dec_valid) begin
        if (opush) begin
          pk_q   <= '0;
          pcnt_q <= '0;
        end else begin
          pk_q   <= pk_word;
          pcnt_q <= pcnt_q + PCW'(1);
        end
      end
      if (idrop && (in_drop_q != '1))  in_drop_q  <= in_drop_q + CNT_W'(1);
      if (odrop && (out_drop_q != '1)) out_drop_q <= out_drop_q + CNT_W'(1);
    end
  end

  assign bus.full_o     = ifull;
  assign bus.valid_o    = !oempty;
  assign bus.data_o     = oempty ? '0 : omem[ord_q[OA-1:0]];
  assign bus.in_drop_o  = in_drop_q;
  assign bus.out_drop_o = out_drop_q;
  assign bus.idle_o     = iempty && (state_q == S_EMPTY) && (pcnt_q == '0) && oempty;
endmodule

// File: tb/tb_viterbi_stream_top.sv
// tb/tb_viterbi_stream_top.sv - self-checking bench for viterbi_stream_top
module tb_viterbi_stream_top;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  viterbi_stream_if #(.IN_W(16), .OUT_W(8), .CNT_W(8)) bus_a ();
  viterbi_stream_if #(.IN_W(12), .OUT_W(6), .CNT_W(8)) bus_b ();

  viterbi_stream_top dut_a (.clk(clk), .rst(rst), .bus(bus_a));
  viterbi_stream_top #(.IN_W(12), .OUT_W(6), .TBL(11)) dut_b (.clk(clk), .rst(rst), .bus(bus_b));

  // Decoder releases source bit n together with code symbol n + TBL + 1.
  localparam int WIN_A = 16;
  localparam int WIN_B = 12;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  always @(posedge clk) cyc++;

  int run_a = 0, nz_a = 0, run_b = 0;
  int runs_a[$], starts_a[$], runs_b[$];
  logic [7:0] got_a[$];
  logic [5:0] got_b[$];

  always @(negedge clk) begin
    if (dut_a.core_valid) begin
      if (run_a == 0) starts_a.push_back(cyc);
      run_a++;
      if (dut_a.core_sym != 2'b00) nz_a++;
    end else if (run_a != 0) begin
      runs_a.push_back(run_a);
      run_a = 0;
    end
    if (dut_b.core_valid) run_b++;
    else if (run_b != 0) begin
      runs_b.push_back(run_b);
      run_b = 0;
    end
    if (bus_a.valid_o && bus_a.ready_i) got_a.push_back(bus_a.data_o);
    if (bus_b.valid_o && bus_b.ready_i) got_b.push_back(bus_b.data_o);
  end

  int hist_a, hist_b;
  logic [7:0] src_a[$];
  logic [5:0] src_b[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference (7,5) encoder: shift register {b, newest, oldest}, each output
  // is the parity of the taps selected by its generator polynomial.
  task automatic enc_word(input int nsym, input logic [7:0] src, inout int hist,
                          output logic [15:0] w);
    w = '0;
    for (int i = nsym - 1; i >= 0; i--) begin
      int r;
      r = (int'(src[i]) << 2) | hist;
      w = (w << 2) | 16'((($countones(r & 7) % 2) << 1) | ($countones(r & 5) % 2));
      hist = r >> 1;
    end
  endtask

  task automatic feed_a(input logic [15:0] w);
    bus_a.dvalid_i = 1'b1;
    bus_a.data_i   = w;
    tick();
    bus_a.dvalid_i = 1'b0;
  endtask

  task automatic byte_a(input logic [7:0] b);
    logic [15:0] w;
    enc_word(8, b, hist_a, w);
    src_a.push_back(b);
    feed_a(w);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus_a.dvalid_i = 1'b0; bus_a.pause_i = 1'b0; bus_a.ready_i = 1'b1;
    bus_b.dvalid_i = 1'b0; bus_b.pause_i = 1'b0; bus_b.ready_i = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    hist_a = 0;
    hist_b = 0;
    src_a.delete();
    src_b.delete();
    tick();
  endtask

  // Compare collected words from index gb onward against the source bytes.
  task automatic words_a(input string tag, input int gb, input int n);
    chk({tag, "_count"}, got_a.size() - gb, n);
    for (int i = 0; i < n; i++)
      chk({tag, "_word"}, (got_a.size() > gb + i) ? got_a[gb + i] : 8'hxx, src_a[i]);
  endtask

  initial begin
    int gb, rb, nzb, c0;
    logic [15:0] w;
    logic [5:0] chunk;
    bus_a.dvalid_i = 1'b0; bus_a.data_i = '0; bus_a.pause_i = 1'b0; bus_a.ready_i = 1'b1;
    bus_b.dvalid_i = 1'b0; bus_b.data_i = '0; bus_b.pause_i = 1'b0; bus_b.ready_i = 1'b1;
    repeat (3) tick();
    chk("rst_valid", bus_a.valid_o, 1'b0);
    chk("rst_data", bus_a.data_o, 8'h00);
    chk("rst_full", bus_a.full_o, 1'b0);
    chk("rst_indrop", bus_a.in_drop_o, 8'd0);
    chk("rst_outdrop", bus_a.out_drop_o, 8'd0);
    chk("rst_idle", bus_a.idle_o, 1'b1);
    chk("rst_idle_b", bus_b.idle_o, 1'b1);
    rst = 1'b0;
    hist_a = 0;
    hist_b = 0;
    tick();

    // All-zero stream: contiguous symbols, fixed latency, zero output words.
    gb = got_a.size(); rb = runs_a.size(); nzb = nz_a; c0 = cyc;
    for (int i = 0; i < 4; i++) byte_a(8'h00);
    repeat (80) tick();
    chk("zero_runs", runs_a.size() - rb, 1);
    chk("zero_len", (runs_a.size() > rb) ? runs_a[rb] : -1, 32);
    chk("zero_latency", (starts_a.size() > rb) ? starts_a[rb] - c0 : -1, 2);
    chk("zero_syms", nz_a - nzb, 0);
    words_a("zero", gb, (4 * 8 - WIN_A) / 8);

    // Encoded byte stream with random input gaps.
    do_reset();
    gb = got_a.size();
    for (int i = 0; i < 12; i++) begin
      byte_a((i == 0) ? 8'hA5 : (i == 1) ? 8'h3C : 8'($urandom));
      repeat ($urandom_range(0, 2)) tick();
    end
    repeat (150) tick();
    words_a("enc", gb, (12 * 8 - WIN_A) / 8);
    chk("enc_idle", bus_a.idle_o, 1'b1);

    // Paused serializer: FIFO fills at 16, 17th word dropped, then drains gap-free.
    do_reset();
    gb = got_a.size();
    bus_a.pause_i = 1'b1;
    for (int i = 0; i < 16; i++) begin
      byte_a(8'($urandom));
      if (i == 14) chk("pause_full15", bus_a.full_o, 1'b0);
    end
    chk("pause_full16", bus_a.full_o, 1'b1);
    chk("pause_drop16", bus_a.in_drop_o, 8'd0);
    feed_a(16'($urandom));
    chk("pause_drop17", bus_a.in_drop_o, 8'd1);
    rb = runs_a.size();
    bus_a.pause_i = 1'b0;
    repeat (200) tick();
    chk("pause_runs", runs_a.size() - rb, 1);
    chk("pause_len", (runs_a.size() > rb) ? runs_a[rb] : -1, 128);
    words_a("pause", gb, (16 * 8 - WIN_A) / 8);
    chk("pause_idle", bus_a.idle_o, 1'b1);

    // Input drop counter saturates, then reset lands mid-stream.
    do_reset();
    bus_a.pause_i = 1'b1;
    bus_a.dvalid_i = 1'b1;
    for (int i = 0; i < 300; i++) begin
      bus_a.data_i = 16'($urandom);
      tick();
    end
    bus_a.dvalid_i = 1'b0;
    chk("sat_indrop", bus_a.in_drop_o, 8'd255);
    chk("sat_full", bus_a.full_o, 1'b1);
    bus_a.pause_i = 1'b0;
    repeat (10) tick();
    chk("mid_busy", bus_a.idle_o, 1'b0);
    rst = 1'b1;
    tick();
    chk("mid_valid", bus_a.valid_o, 1'b0);
    chk("mid_full", bus_a.full_o, 1'b0);
    chk("mid_indrop", bus_a.in_drop_o, 8'd0);
    chk("mid_outdrop", bus_a.out_drop_o, 8'd0);
    chk("mid_idle", bus_a.idle_o, 1'b1);

    // Output backpressure: 8 words held, the rest counted as dropped.
    do_reset();
    gb = got_a.size();
    bus_a.ready_i = 1'b0;
    for (int i = 0; i < 16; i++) byte_a(8'($urandom));
    repeat (200) tick();
    chk("bp_outdrop", bus_a.out_drop_o, 8'((16 * 8 - WIN_A) / 8 - 8));
    chk("bp_valid", bus_a.valid_o, 1'b1);
    chk("bp_head", bus_a.data_o, src_a[0]);
    repeat (5) tick();
    chk("bp_hold", bus_a.data_o, src_a[0]);
    bus_a.ready_i = 1'b1;
    repeat (20) tick();
    words_a("bp", gb, 8);
    chk("bp_empty", bus_a.valid_o, 1'b0);
    chk("bp_idle", bus_a.idle_o, 1'b1);

    // Narrow variant: 6 symbols per 12-bit word, 6-bit output words.
    do_reset();
    gb = got_b.size();
    rb = runs_b.size();
    for (int i = 0; i < 10; i++) begin
      chunk = 6'($urandom);
      enc_word(6, {2'b00, chunk}, hist_b, w);
      src_b.push_back(chunk);
      bus_b.dvalid_i = 1'b1;
      bus_b.data_i   = w[11:0];
      tick();
    end
    bus_b.dvalid_i = 1'b0;
    repeat (150) tick();
    chk("b_len", (runs_b.size() > rb) ? runs_b[rb] : -1, 60);
    chk("b_count", got_b.size() - gb, (10 * 6 - WIN_B) / 6);
    for (int i = 0; i < (10 * 6 - WIN_B) / 6; i++)
      chk("b_word", (got_b.size() > gb + i) ? got_b[gb + i] : 6'hxx, src_b[i]);
    chk("b_idle", bus_b.idle_o, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
